// File: rtl/ppl_arbiter_pkg.sv
// Shared pixel-pipeline definitions: field widths, frame-size helper and
// packed-bus slice helpers used by the render pipelines and the arbiter.
package ppl_arbiter_pkg;

    localparam int unsigned PIX_W   = 24;
    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned MAX_REQ = 8;

    localparam int unsigned H_DISP_DEF = 1280;
    localparam int unsigned V_DISP_DEF = 720;

    typedef struct packed {
        logic [PIX_W-1:0]  data;
        logic [ADDR_W-1:0] addr;
    } pixel_t;

    // Pixels per frame, one bit wider than an address so the window
    // limit can be compared without overflow.
    function automatic logic [ADDR_W:0] frame_pixels(input int unsigned h,
                                                     input int unsigned v);
        return (ADDR_W+1)'(h * v);
    endfunction

    function automatic logic [PIX_W-1:0] pix_slice(input logic [PIX_W*MAX_REQ-1:0] bus,
                                                   input int unsigned idx);
        return bus[PIX_W*idx +: PIX_W];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_slice(input logic [ADDR_W*MAX_REQ-1:0] bus,
                                                     input int unsigned idx);
        return bus[ADDR_W*idx +: ADDR_W];
    endfunction

endpackage

// File: rtl/ppl_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first eligible index at or
// after the pointer, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] rr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(N);

    int unsigned cand;

    // Scan from the pointer upward, wrapping once, and keep the first hit.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(rr) + k;
            if (cand >= N) cand = cand - N;
            if (!any && eligible[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/ppl_arbiter.sv
// Round-robin merge of NUM_REQ pixel streams into one registered stream,
// gated by a line window that tracks how far downstream has drained.
module ppl_arbiter
    import ppl_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned H_DISP      = H_DISP_DEF,
    parameter int unsigned V_DISP      = V_DISP_DEF,
    parameter int unsigned LINE_WINDOW = 2
) (
    input  logic                         PPL_clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [PIX_W*NUM_REQ-1:0]     req_data,
    input  logic [ADDR_W*NUM_REQ-1:0]    req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         line_release,
    input  logic                         frame_start,
    output logic                         out_valid,
    output logic [PIX_W-1:0]             out_data,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
    output logic                         frame_done,
    output logic                         addr_err
);

    localparam int unsigned     IDX_W = $clog2(NUM_REQ);
    localparam logic [ADDR_W:0] FRAME = frame_pixels(H_DISP, V_DISP);
    localparam logic [ADDR_W:0] LAST  = FRAME - (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(LINE_WINDOW * H_DISP);
    localparam logic [ADDR_W:0] LINE  = (ADDR_W+1)'(H_DISP);

    logic [ADDR_W-1:0]          base;
    logic [ADDR_W-1:0]          pix_cnt;
    logic [IDX_W-1:0]           rr;
    logic [ADDR_W:0]            base_span;
    logic [ADDR_W:0]            limit;
    logic [ADDR_W:0]            base_step;
    logic [ADDR_W-1:0]          base_next;
    logic [PIX_W*MAX_REQ-1:0]   data_bus;
    logic [ADDR_W*MAX_REQ-1:0]  addr_bus;
    pixel_t                     pix_in [NUM_REQ];
    logic [NUM_REQ-1:0]         eligible;
    logic [NUM_REQ-1:0]         late;
    logic [NUM_REQ-1:0]         grant;
    logic [IDX_W-1:0]           pick;
    logic                       any;
    logic                       accept;
    logic [IDX_W-1:0]           rr_next;
    pixel_t                     out_q;

    // Window bounds: limit and next base are saturated to the frame size.
    always_comb begin
        base_span = {1'b0, base} + SPAN;
        limit     = (base_span > FRAME) ? FRAME : base_span;
        base_step = {1'b0, base} + LINE;
        base_next = (base_step > FRAME) ? FRAME[ADDR_W-1:0] : base_step[ADDR_W-1:0];
    end

    // Unpack the requester buses and classify each pixel against the window.
    always_comb begin
        data_bus = '0;
        addr_bus = '0;
        data_bus[PIX_W*NUM_REQ-1:0]  = req_data;
        addr_bus[ADDR_W*NUM_REQ-1:0] = req_addr;
        eligible = '0;
        late     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pix_in[i].data = pix_slice(data_bus, i);
            pix_in[i].addr = addr_slice(addr_bus, i);
            eligible[i]    = req_valid[i] && ({1'b0, pix_in[i].addr} < limit);
            late[i]        = req_valid[i] && (pix_in[i].addr < base);
        end
    end

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .eligible (eligible),
        .rr       (rr),
        .grant    (grant),
        .idx      (pick),
        .any      (any)
    );

    // Late pixels are still handshaked so the pipeline drains, but never emitted.
    always_comb begin
        req_ready = grant;
        accept    = any && !late[pick];
        rr_next   = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
    end

    // Window base, pixel counter, error flag and round-robin pointer.
    always_ff @(posedge PPL_clk or negedge rst_n) begin
        if (!rst_n) begin
            base     <= '0;
            pix_cnt  <= '0;
            addr_err <= 1'b0;
            rr       <= '0;
        end else begin
            if (any) rr <= rr_next;
            if (frame_start) begin
                base     <= '0;
                pix_cnt  <= '0;
                addr_err <= 1'b0;
            end else begin
                if (line_release) base <= base_next;
                if (any && late[pick]) addr_err <= 1'b1;
                if (accept) pix_cnt <= ({1'b0, pix_cnt} == LAST) ? '0 : pix_cnt + ADDR_W'(1);
            end
        end
    end

    // Output register: one-cycle valid per accepted pixel, end-of-frame pulse.
    always_ff @(posedge PPL_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_q      <= '0;
            grant_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= accept;
            frame_done <= accept && ({1'b0, pix_cnt} == LAST);
            if (accept) begin
                out_q     <= pix_in[pick];
                grant_idx <= pick;
            end
        end
    end

    assign out_data = out_q.data;
    assign out_addr = out_q.addr;

endmodule

// File: tb/tb_ppl_arbiter.sv
// Randomised and directed bench for ppl_arbiter against a behavioural model
// of the window/round-robin rules, using a reduced frame geometry.
module tb_ppl_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned H     = 32;
    localparam int unsigned V     = 12;
    localparam int unsigned LW    = 2;
    localparam int          FRAME = H * V;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [24*N-1:0]   req_data = '0;
    logic [20*N-1:0]   req_addr = '0;
    logic [N-1:0]      req_ready;
    logic              line_release = 1'b0;
    logic              frame_start = 1'b0;
    logic              out_valid;
    logic [23:0]       out_data;
    logic [19:0]       out_addr;
    logic [1:0]        grant_idx;
    logic              frame_done;
    logic              addr_err;

    always #5 clk = ~clk;

    ppl_arbiter #(
        .NUM_REQ     (N),
        .H_DISP      (H),
        .V_DISP      (V),
        .LINE_WINDOW (LW)
    ) dut (
        .PPL_clk      (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .line_release (line_release),
        .frame_start  (frame_start),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .grant_idx    (grant_idx),
        .frame_done   (frame_done),
        .addr_err     (addr_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stimulus state
    logic [N-1:0] drv_valid = '0;
    int           drv_addr [N];
    logic [23:0]  drv_data [N];
    bit           rel = 0;
    bit           fs  = 0;

    // reference model state
    int          m_base = 0, m_pix = 0, m_rr = 0, m_g = -1;
    bit          m_err = 0;
    bit          m_acc = 0;
    logic [23:0] m_data = '0;
    int          m_addr = 0, m_idx = 0;
    int          done_count = 0;

    function automatic int m_limit();
        return (m_base + LW * H < FRAME) ? m_base + LW * H : FRAME;
    endfunction

    task automatic model_reset();
        m_base = 0; m_pix = 0; m_rr = 0; m_err = 0; m_g = -1; m_acc = 0;
    endtask

    // One clock: drive inputs, check the combinational grant, then check outputs.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        bit           fd;
        for (int i = 0; i < N; i++) begin
            req_data[24*i +: 24] = drv_data[i];
            req_addr[20*i +: 20] = 20'(drv_addr[i]);
        end
        req_valid    = drv_valid;
        line_release = rel;
        frame_start  = fs;
        #1;
        m_g = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (m_g < 0 && drv_valid[i] && drv_addr[i] < m_limit()) m_g = i;
        end
        exp_ready = '0;
        if (m_g >= 0) exp_ready[m_g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        m_acc = (m_g >= 0) && (drv_addr[m_g] >= m_base);
        fd    = m_acc && (m_pix == FRAME - 1);
        @(posedge clk);
        #1;
        if (m_g >= 0) m_rr = (m_g + 1) % N;
        if (m_acc) begin
            m_data = drv_data[m_g];
            m_addr = drv_addr[m_g];
            m_idx  = m_g;
            m_pix  = (m_pix == FRAME - 1) ? 0 : m_pix + 1;
        end
        if (m_g >= 0 && !m_acc) m_err = 1;
        if (fs) begin
            m_base = 0; m_pix = 0; m_err = 0;
        end else if (rel) begin
            m_base = (m_base + H > FRAME) ? FRAME : m_base + H;
        end
        check("out_valid", out_valid, m_acc);
        check("frame_done", frame_done, fd);
        check("addr_err", addr_err, m_err);
        if (m_acc) begin
            check("out_data", out_data, m_data);
            check("out_addr", out_addr, m_addr);
            check("grant_idx", grant_idx, m_idx);
        end
        if (frame_done) done_count++;
        rel = 0;
        fs  = 0;
    endtask

    task automatic retire();
        if (m_g >= 0) drv_valid[m_g] = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_addr"}, out_addr, 0);
        check({tag, "_idx"}, grant_idx, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_err"}, addr_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int next;
        int budget;
        for (int i = 0; i < N; i++) begin
            drv_addr[i] = 0;
            drv_data[i] = '0;
        end

        // reset state
        #12;
        check_outputs_zero("reset");
        check("reset_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // all four valid at addrs 0..3 -> grants 0,1,2,3 back to back
        for (int i = 0; i < N; i++) begin
            drv_valid[i] = 1'b1;
            drv_addr[i]  = i;
            drv_data[i]  = 24'($urandom);
        end
        for (int k = 0; k < N; k++) begin
            cycle();
            check("t1_idx", grant_idx, k);
            check("t1_addr", out_addr, k);
            retire();
        end
        cycle();

        // pixel two lines ahead waits until a line is released
        drv_valid[1] = 1'b1;
        drv_addr[1]  = 2 * H;
        drv_data[1]  = 24'h123456;
        cycle();
        cycle();
        check("t2_wait", req_ready[1], 0);
        rel = 1;
        cycle();
        cycle();
        check("t2_grant_valid", out_valid, 1);
        check("t2_grant_idx", grant_idx, 1);
        retire();

        // late pixel below base is dropped and flags addr_err
        fs = 1;
        cycle();
        rel = 1;
        cycle();
        rel = 1;
        cycle();
        drv_valid[2] = 1'b1;
        drv_addr[2]  = 5;
        drv_data[2]  = 24'hABCDEF;
        cycle();
        check("t3_dropped", out_valid, 0);
        check("t3_err", addr_err, 1);
        retire();
        repeat (3) cycle();
        check("t3_sticky", addr_err, 1);
        fs = 1;
        cycle();
        check("t3_cleared", addr_err, 0);

        // frame_start beats line_release in the same cycle
        rel = 1;
        cycle();
        fs  = 1;
        rel = 1;
        cycle();
        drv_valid[0] = 1'b1;
        drv_addr[0]  = LW * H;
        cycle();
        check("t5_base0", req_ready[0], 0);
        drv_valid[0] = 1'b0;
        cycle();

        // stream a whole frame in order from requester 0
        fs = 1;
        cycle();
        done_count = 0;
        next   = 0;
        budget = 0;
        while (next < FRAME && budget < 3 * FRAME) begin
            drv_valid[0] = 1'b1;
            drv_addr[0]  = next;
            drv_data[0]  = 24'($urandom);
            cycle();
            budget++;
            if (m_g == 0) begin
                next++;
                if (next % H == 0) rel = 1;
            end
        end
        drv_valid[0] = 1'b0;
        cycle();
        if (next != FRAME) check("stream_timeout", next, FRAME);
        check("frame_done_count", done_count, 1);

        // reset mid-burst
        fs = 1;
        cycle();
        for (int i = 0; i < N; i++) begin
            drv_valid[i] = 1'b1;
            drv_addr[i]  = 10 + i;
        end
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            drv_valid[i] = 1'b1;
            drv_addr[i]  = i;
        end
        cycle();
        check("t6_first_idx", grant_idx, 0);
        check("t6_first_valid", out_valid, 1);
        retire();

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!drv_valid[i] && $urandom_range(1, 0) == 1) begin
                    int lo, hi;
                    lo = (m_base > H / 2) ? m_base - H / 2 : 0;
                    hi = (m_base + (LW + 1) * H < FRAME) ? m_base + (LW + 1) * H : FRAME - 1;
                    if (lo > hi) lo = hi;
                    drv_valid[i] = 1'b1;
                    drv_addr[i]  = $urandom_range(hi, lo);
                    drv_data[i]  = 24'($urandom);
                end
            end
            rel = ($urandom_range(11, 0) == 0);
            fs  = ($urandom_range(79, 0) == 0);
            cycle();
            retire();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
